// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache.
// Read misses refill a whole line; stores always go to memory.
module data_cache #(
    parameter int SETS           = 8,
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [3:0][7:0]   cpu_wdata,
    output logic [3:0][7:0]   cpu_rdata,
    output logic              cpu_stall,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0][7:0]   mem_wdata,
    input  logic [3:0][7:0]   mem_rdata,
    input  logic              mem_ack
);

    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(SETS);
    localparam int LO    = OFF_W + 2;
    localparam int TAG_W = ADDR_W - LO - IDX_W;
    localparam logic [OFF_W-1:0] LAST = OFF_W'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        WRITE
    } state_e;

    state_e            state_q;
    logic [SETS-1:0]   valid_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [31:0]       data_q [SETS][WORDS_PER_LINE];
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [OFF_W-1:0]  cnt_q;
    logic [OFF_W-1:0]  cnt_d;

    logic [IDX_W-1:0]  c_idx;
    logic [TAG_W-1:0]  c_tag;
    logic [OFF_W-1:0]  c_off;
    logic              c_hit;
    logic [IDX_W-1:0]  a_idx;
    logic [TAG_W-1:0]  a_tag;
    logic [OFF_W-1:0]  a_off;
    logic              a_hit;
    logic              unused_lsb;

    assign c_idx = cpu_addr[LO +: IDX_W];
    assign c_tag = cpu_addr[ADDR_W-1 -: TAG_W];
    assign c_off = cpu_addr[2 +: OFF_W];
    assign c_hit = valid_q[c_idx] && (tag_q[c_idx] == c_tag);

    assign a_idx = addr_q[LO +: IDX_W];
    assign a_tag = addr_q[ADDR_W-1 -: TAG_W];
    assign a_off = addr_q[2 +: OFF_W];
    assign a_hit = valid_q[a_idx] && (tag_q[a_idx] == a_tag);

    assign cnt_d      = cnt_q + 1'b1;
    assign unused_lsb = ^addr_q[1:0];

    assign mem_req   = (state_q != IDLE) && !rst_b;
    assign mem_we    = (state_q == WRITE);
    assign mem_wdata = wdata_q;
    assign mem_addr  = (state_q == REFILL)
                     ? {addr_q[ADDR_W-1:LO], cnt_q, 2'b00}
                     : {addr_q[ADDR_W-1:2], 2'b00};

    always_comb begin
        cpu_stall = 1'b0;
        cpu_rdata = '0;
        unique case (state_q)
            IDLE: begin
                if (cpu_wr) begin
                    cpu_stall = 1'b1;
                end else if (cpu_rd) begin
                    if (c_hit) cpu_rdata = data_q[c_idx][c_off];
                    else       cpu_stall = 1'b1;
                end
            end
            REFILL:  cpu_stall = 1'b1;
            WRITE:   cpu_stall = !mem_ack;
            default: cpu_stall = 1'b0;
        endcase
        if (rst_b) cpu_stall = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            state_q <= IDLE;
            valid_q <= '0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cpu_wr) begin
                        addr_q  <= cpu_addr;
                        wdata_q <= cpu_wdata;
                        state_q <= WRITE;
                    end else if (cpu_rd && !c_hit) begin
                        // line is invisible until every word has arrived
                        addr_q         <= cpu_addr;
                        cnt_q          <= '0;
                        valid_q[c_idx] <= 1'b0;
                        state_q        <= REFILL;
                    end
                end
                REFILL: begin
                    if (mem_ack) begin
                        data_q[a_idx][cnt_q] <= mem_rdata;
                        cnt_q <= cnt_d;
                        if (cnt_q == LAST) begin
                            tag_q[a_idx]   <= a_tag;
                            valid_q[a_idx] <= 1'b1;
                            state_q        <= IDLE;
                        end
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        if (a_hit) data_q[a_idx][a_off] <= wdata_q;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache against a fixed-latency memory.
// Loads push expected words; the monitor pops on unstalled loads.
module tb_data_cache;

    localparam int LAT = 2;

    logic            clk = 1'b0;
    logic            rst_b = 1'b1;
    logic [31:0]     cpu_addr = '0;
    logic            cpu_rd = 1'b0;
    logic            cpu_wr = 1'b0;
    logic [3:0][7:0] cpu_wdata = '0;
    logic [3:0][7:0] cpu_rdata;
    logic            cpu_stall;
    logic [31:0]     mem_addr;
    logic            mem_req;
    logic            mem_we;
    logic [3:0][7:0] mem_wdata;
    logic [3:0][7:0] mem_rdata = '0;
    logic            mem_ack = 1'b0;

    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    logic [31:0] sb       [$];
    logic [31:0] addr_log [$];
    int          cyc = 0;
    int          ack_cnt = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    data_cache dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .cpu_addr  (cpu_addr),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .mem_addr  (mem_addr),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag,
                            input logic [31:0] got,
                            input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ack on the LAT-th cycle of each request
    always @(posedge clk) begin
        #2;
        mem_ack = 1'b0;
        if (mem_req) begin
            cyc++;
            if (cyc == LAT) begin
                cyc = 0;
                mem_ack = 1'b1;
                ack_cnt++;
                addr_log.push_back(mem_addr);
                if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
                else        mem_rdata = mem[mem_addr[9:2]];
            end
        end else begin
            cyc = 0;
        end
    end

    always @(negedge clk) begin
        if (!rst_b && cpu_rd && !cpu_wr && !cpu_stall) begin
            if (sb.size() == 0) check_eq("sb_underflow", 32'd1, 32'd0);
            else check_eq("load_data", cpu_rdata, sb.pop_front());
        end
    end

    task automatic do_load(input logic [31:0] a,
                           input int es, input int er);
        int stalls = 0;
        int reqs = 0;
        bit done = 1'b0;
        addr_log.delete();
        cpu_addr = a;
        cpu_rd = 1'b1;
        sb.push_back(ref_mem[a[9:2]]);
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (mem_req) reqs++;
            if (!cpu_stall) done = 1'b1;
            else stalls++;
        end
        check_eq("ld_done", 32'(done), 32'd1);
        check_eq("ld_stall", 32'(stalls), 32'(es));
        check_eq("ld_req", 32'(reqs), 32'(er));
        @(posedge clk);
        #1 cpu_rd = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] a,
                            input logic [31:0] d);
        int stalls = 0;
        int reqs = 0;
        bit done = 1'b0;
        addr_log.delete();
        cpu_addr = a;
        cpu_wdata = d;
        cpu_wr = 1'b1;
        ref_mem[a[9:2]] = d;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (mem_req && mem_we) reqs++;
            if (!cpu_stall) done = 1'b1;
            else stalls++;
        end
        check_eq("st_done", 32'(done), 32'd1);
        check_eq("st_stall", 32'(stalls), 32'(LAT));
        check_eq("st_req", 32'(reqs), 32'(LAT));
        check_eq("st_nlog", 32'(addr_log.size()), 32'd1);
        if (addr_log.size() > 0) check_eq("st_addr", addr_log[0], a);
        check_eq("st_mem", mem[a[9:2]], d);
        @(posedge clk);
        #1 cpu_wr = 1'b0;
    endtask

    task automatic check_log(input logic [31:0] base);
        check_eq("log_n", 32'(addr_log.size()), 32'd4);
        for (int i = 0; i < addr_log.size() && i < 4; i++)
            check_eq("refill_addr", addr_log[i], base + 32'(4 * i));
    endtask

    initial begin
        int base;
        bit ok;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'hC0DE0000 | 32'(i);
            ref_mem[i] = mem[i];
        end
        repeat (2) @(posedge clk);
        #1 rst_b = 1'b0;
        @(negedge clk);
        check_eq("rst_stall", 32'(cpu_stall), 32'd0);
        check_eq("rst_req", 32'(mem_req), 32'd0);
        check_eq("rst_rdata", cpu_rdata, 32'd0);
        @(posedge clk);
        #1;

        do_load(32'h40, 9, 8);
        check_log(32'h40);
        do_load(32'h44, 0, 0);
        do_load(32'h4C, 0, 0);

        do_store(32'h48, 32'hDEADBEEF);
        do_load(32'h48, 0, 0);

        do_store(32'h200, 32'h12345678);
        do_load(32'h200, 9, 8);
        check_log(32'h200);

        do_load(32'h40, 0, 0);
        do_load(32'hC0, 9, 8);
        check_log(32'hC0);
        do_load(32'h40, 9, 8);

        addr_log.delete();
        base = ack_cnt;
        ok = 1'b0;
        cpu_addr = 32'h100;
        cpu_rd = 1'b1;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(posedge clk);
            if (ack_cnt - base >= 2) ok = 1'b1;
        end
        check_eq("abort_reach", 32'(ok), 32'd1);
        #1 rst_b = 1'b1;
        @(negedge clk);
        check_eq("abort_stall", 32'(cpu_stall), 32'd0);
        @(posedge clk);
        #1;
        rst_b = 1'b0;
        cpu_rd = 1'b0;
        @(negedge clk);
        check_eq("abort_req", 32'(mem_req), 32'd0);
        check_eq("abort_idle", 32'(cpu_stall), 32'd0);
        @(posedge clk);
        #1;
        do_load(32'h100, 9, 8);
        check_log(32'h100);

        check_eq("sb_left", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
